// File: rtl/lsu_dmem_port.sv
// Load/store initiator between the execute stage and byte-addressed data memory.
// Decodes RV32 width/sign, positions store lanes, splits word-crossing accesses.
module lsu_dmem_port #(
   parameter int unsigned ALIGN_SPLIT = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_store,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic [31:0] daddr,
   output logic [31:0] dwdata,
   output logic [3:0]  we,
   input  logic [31:0] drdata
);

   typedef enum logic [1:0] {StIdle, StAcc0, StAcc1, StResp} state_e;

   state_e      state_q, state_d;
   logic        store_q, store_d;
   logic [2:0]  funct3_q, funct3_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] lo_q, lo_d;
   logic [31:0] hi_q, hi_d;
   logic [31:0] daddr_q, daddr_d;
   logic [31:0] dwdata_q, dwdata_d;
   logic [3:0]  we_q, we_d;
   logic [31:0] rdata_q, rdata_d;
   logic        err_q, err_d;

   logic [7:0]  m_req, m_cur;
   logic [63:0] s_req, s_cur;
   logic        cross_req, cross_cur;

   // Byte mask over two consecutive words, shifted to the access offset.
   function automatic logic [7:0] lane_mask(input logic [2:0] f3, input logic [1:0] off);
      logic [7:0] m;
      case (f3[1:0])
         2'b00:   m = 8'h01;
         2'b01:   m = 8'h03;
         default: m = 8'h0F;
      endcase
      return m << off;
   endfunction

   function automatic logic [63:0] lane_data(input logic [31:0] wd, input logic [1:0] off);
      return {32'b0, wd} << {off, 3'b000};
   endfunction

   function automatic logic legal_op(input logic st, input logic [2:0] f3);
      case (f3)
         3'b000, 3'b001, 3'b010: return 1'b1;
         3'b100, 3'b101:         return !st;
         default:                return 1'b0;
      endcase
   endfunction

   function automatic logic [31:0] extend(input logic [2:0] f3, input logic [1:0] off,
                                          input logic [31:0] hi, input logic [31:0] lo);
      logic [63:0] t;
      t = {hi, lo} >> {off, 3'b000};
      case (f3)
         3'b000:  return {{24{t[7]}}, t[7:0]};
         3'b001:  return {{16{t[15]}}, t[15:0]};
         3'b100:  return {24'b0, t[7:0]};
         3'b101:  return {16'b0, t[15:0]};
         default: return t[31:0];
      endcase
   endfunction

   assign m_req     = lane_mask(req_funct3, req_addr[1:0]);
   assign s_req     = lane_data(req_wdata, req_addr[1:0]);
   assign cross_req = |m_req[7:4];
   assign m_cur     = lane_mask(funct3_q, addr_q[1:0]);
   assign s_cur     = lane_data(wdata_q, addr_q[1:0]);
   assign cross_cur = |m_cur[7:4];

   always_comb begin
      state_d  = state_q;
      store_d  = store_q;
      funct3_d = funct3_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      lo_d     = lo_q;
      hi_d     = hi_q;
      daddr_d  = daddr_q;
      dwdata_d = dwdata_q;
      we_d     = 4'b0;
      rdata_d  = rdata_q;
      err_d    = err_q;
      case (state_q)
         StIdle: begin
            if (req_valid) begin
               store_d  = req_store;
               funct3_d = req_funct3;
               addr_d   = req_addr;
               wdata_d  = req_wdata;
               if (!legal_op(req_store, req_funct3) || (cross_req && (ALIGN_SPLIT == 0))) begin
                  state_d = StResp;
                  err_d   = 1'b1;
                  rdata_d = 32'b0;
               end else begin
                  state_d  = StAcc0;
                  daddr_d  = {req_addr[31:2], 2'b00};
                  dwdata_d = s_req[31:0];
                  we_d     = req_store ? m_req[3:0] : 4'b0;
               end
            end
         end
         StAcc0: begin
            lo_d = drdata;
            if (cross_cur) begin
               state_d  = StAcc1;
               daddr_d  = {addr_q[31:2], 2'b00} + 32'd4;
               dwdata_d = s_cur[63:32];
               we_d     = store_q ? m_cur[7:4] : 4'b0;
            end else begin
               state_d = StResp;
               err_d   = 1'b0;
               rdata_d = store_q ? 32'b0 : extend(funct3_q, addr_q[1:0], hi_q, drdata);
            end
         end
         StAcc1: begin
            hi_d    = drdata;
            state_d = StResp;
            err_d   = 1'b0;
            rdata_d = store_q ? 32'b0 : extend(funct3_q, addr_q[1:0], drdata, lo_q);
         end
         StResp: begin
            if (resp_ready) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= StIdle;
         store_q  <= 1'b0;
         funct3_q <= 3'b0;
         addr_q   <= 32'b0;
         wdata_q  <= 32'b0;
         lo_q     <= 32'b0;
         hi_q     <= 32'b0;
         daddr_q  <= 32'b0;
         dwdata_q <= 32'b0;
         we_q     <= 4'b0;
         rdata_q  <= 32'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         store_q  <= store_d;
         funct3_q <= funct3_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         lo_q     <= lo_d;
         hi_q     <= hi_d;
         daddr_q  <= daddr_d;
         dwdata_q <= dwdata_d;
         we_q     <= we_d;
         rdata_q  <= rdata_d;
         err_q    <= err_d;
      end
   end

   assign req_ready  = (state_q == StIdle);
   assign resp_valid = (state_q == StResp);
   assign resp_rdata = rdata_q;
   assign resp_err   = err_q;
   assign daddr      = daddr_q;
   assign dwdata     = dwdata_q;
   assign we         = we_q;

endmodule

// File: tb/tb_lsu_dmem_port.sv
// Directed bench for lsu_dmem_port with a small byte-addressed memory model.
module tb_lsu_dmem_port;

   logic        clk, rst_n;
   logic        req_valid, req_ready, req_store;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr, req_wdata;
   logic        resp_valid, resp_ready, resp_err;
   logic [31:0] resp_rdata, daddr, dwdata, drdata;
   logic [3:0]  we;

   logic        req_valid0, req_ready0, resp_valid0, resp_ready0, resp_err0;
   logic [31:0] resp_rdata0, daddr0, dwdata0;
   logic [3:0]  we0;
   logic [31:0] drdata0;

   bit   [7:0]  mem [0:63];
   int          n_assert = 0;
   int          n_fail = 0;

   lsu_dmem_port #(.ALIGN_SPLIT(1)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
      .req_store(req_store), .req_funct3(req_funct3), .req_addr(req_addr),
      .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_rdata(resp_rdata), .resp_err(resp_err), .daddr(daddr), .dwdata(dwdata),
      .we(we), .drdata(drdata)
   );

   lsu_dmem_port #(.ALIGN_SPLIT(0)) dut0 (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid0), .req_ready(req_ready0),
      .req_store(req_store), .req_funct3(req_funct3), .req_addr(req_addr),
      .req_wdata(req_wdata), .resp_valid(resp_valid0), .resp_ready(resp_ready0),
      .resp_rdata(resp_rdata0), .resp_err(resp_err0), .daddr(daddr0), .dwdata(dwdata0),
      .we(we0), .drdata(drdata0)
   );

   assign drdata0 = 32'h0;
   assign drdata  = {mem[{daddr[5:2], 2'd3}], mem[{daddr[5:2], 2'd2}],
                     mem[{daddr[5:2], 2'd1}], mem[{daddr[5:2], 2'd0}]};

   always @(posedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (we[i]) mem[{daddr[5:2], i[1:0]}] <= dwdata[8*i +: 8];
      end
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic st, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd);
      req_store  = st;
      req_funct3 = f3;
      req_addr   = a;
      req_wdata  = wd;
      req_valid  = 1'b1;
   endtask

   task automatic handshake(input string tag);
      resp_ready = 1'b1;
      @(posedge clk); #1;
      resp_ready = 1'b0;
      check({tag, "_hs_valid"}, resp_valid, 32'd0);
      check({tag, "_hs_ready"}, req_ready, 32'd1);
   endtask

   // Issue one request, measure edges until resp_valid, check response and write activity.
   task automatic run(input string tag, input logic st, input logic [2:0] f3,
                      input logic [31:0] a, input logic [31:0] wd, input int exp_lat,
                      input logic exp_err, input logic [31:0] exp_rd, input logic exp_we_any);
      int   cyc;
      logic we_any;
      drive(st, f3, a, wd);
      @(posedge clk); #1;
      req_valid = 1'b0;
      cyc = 1;
      we_any = (we != 4'b0);
      while (!resp_valid && cyc < 8) begin
         @(posedge clk); #1;
         cyc++;
         if (we != 4'b0) we_any = 1'b1;
      end
      check({tag, "_lat"}, cyc, exp_lat);
      check({tag, "_err"}, resp_err, exp_err);
      check({tag, "_rdata"}, resp_rdata, exp_rd);
      check({tag, "_we_any"}, we_any, exp_we_any);
      handshake(tag);
   endtask

   initial begin
      rst_n = 1'b0;
      req_valid = 1'b0; req_valid0 = 1'b0; resp_ready = 1'b0; resp_ready0 = 1'b0;
      req_store = 1'b0; req_funct3 = 3'b0; req_addr = 32'b0; req_wdata = 32'b0;
      #2;
      check("rst_req_ready", req_ready, 32'd1);
      check("rst_resp_valid", resp_valid, 32'd0);
      check("rst_rdata", resp_rdata, 32'd0);
      check("rst_err", resp_err, 32'd0);
      check("rst_daddr", daddr, 32'd0);
      check("rst_dwdata", dwdata, 32'd0);
      check("rst_we", we, 32'd0);
      #10 rst_n = 1'b1;
      @(posedge clk); #1;

      // Aligned word store
      drive(1'b1, 3'b010, 32'h10, 32'hDEADBEEF);
      @(posedge clk); #1;
      req_valid = 1'b0;
      check("sw_daddr", daddr, 32'h10);
      check("sw_we", we, 32'hF);
      check("sw_dwdata", dwdata, 32'hDEADBEEF);
      check("sw_acc0_valid", resp_valid, 32'd0);
      @(posedge clk); #1;
      check("sw_valid", resp_valid, 32'd1);
      check("sw_err", resp_err, 32'd0);
      check("sw_rdata", resp_rdata, 32'd0);
      handshake("sw");

      run("lb", 1'b0, 3'b000, 32'h11, 32'h0, 2, 1'b0, 32'hFFFFFFBE, 1'b0);
      run("lbu", 1'b0, 3'b100, 32'h11, 32'h0, 2, 1'b0, 32'h000000BE, 1'b0);
      run("lh", 1'b0, 3'b001, 32'h12, 32'h0, 2, 1'b0, 32'hFFFFDEAD, 1'b0);

      // Word-crossing halfword store
      drive(1'b1, 3'b001, 32'h13, 32'h00001234);
      @(posedge clk); #1;
      req_valid = 1'b0;
      check("sh_acc0_daddr", daddr, 32'h10);
      check("sh_acc0_we", we, 32'h8);
      check("sh_acc0_byte", dwdata[31:24], 32'h34);
      @(posedge clk); #1;
      check("sh_acc1_daddr", daddr, 32'h14);
      check("sh_acc1_we", we, 32'h1);
      check("sh_acc1_byte", dwdata[7:0], 32'h12);
      check("sh_acc1_valid", resp_valid, 32'd0);
      @(posedge clk); #1;
      check("sh_valid", resp_valid, 32'd1);
      check("sh_err", resp_err, 32'd0);
      check("sh_rdata", resp_rdata, 32'd0);
      handshake("sh");

      run("lhu_x", 1'b0, 3'b101, 32'h13, 32'h0, 3, 1'b0, 32'h00001234, 1'b0);
      run("ill_ld", 1'b0, 3'b011, 32'h10, 32'h0, 1, 1'b1, 32'h0, 1'b0);
      run("ill_st", 1'b1, 3'b100, 32'h10, 32'hFFFFFFFF, 1, 1'b1, 32'h0, 1'b0);
      run("lw_chk", 1'b0, 3'b010, 32'h10, 32'h0, 2, 1'b0, 32'h34ADBEEF, 1'b0);

      // Misaligned LW rejected when splitting is disabled
      req_store = 1'b0; req_funct3 = 3'b010; req_addr = 32'h02; req_wdata = 32'h0;
      req_valid0 = 1'b1;
      @(posedge clk); #1;
      req_valid0 = 1'b0;
      check("ns_valid", resp_valid0, 32'd1);
      check("ns_err", resp_err0, 32'd1);
      check("ns_rdata", resp_rdata0, 32'd0);
      check("ns_we", we0, 32'd0);
      check("ns_daddr", daddr0, 32'd0);
      resp_ready0 = 1'b1;
      @(posedge clk); #1;
      resp_ready0 = 1'b0;
      check("ns_hs_ready", req_ready0, 32'd1);

      // Backpressure with a competing request held on req_valid
      drive(1'b0, 3'b010, 32'h10, 32'h0);
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(posedge clk); #1;
      check("bp_valid0", resp_valid, 32'd1);
      drive(1'b0, 3'b000, 32'h10, 32'h0);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         check("bp_hold_valid", resp_valid, 32'd1);
         check("bp_hold_rdata", resp_rdata, 32'h34ADBEEF);
         check("bp_hold_ready", req_ready, 32'd0);
      end
      resp_ready = 1'b1;
      @(posedge clk); #1;
      resp_ready = 1'b0;
      check("bp_hs_valid", resp_valid, 32'd0);
      check("bp_hs_ready", req_ready, 32'd1);
      @(posedge clk); #1;
      req_valid = 1'b0;
      check("bp_acc_ready", req_ready, 32'd0);
      check("bp_acc_daddr", daddr, 32'h10);
      @(posedge clk); #1;
      check("bp_lb_valid", resp_valid, 32'd1);
      check("bp_lb_rdata", resp_rdata, 32'hFFFFFFEF);
      handshake("bp");

      // Reset asserted during the second half of a crossing store
      drive(1'b1, 3'b010, 32'h12, 32'hCAFEF00D);
      @(posedge clk); #1;
      req_valid = 1'b0;
      check("rs_acc0_we", we, 32'hC);
      check("rs_acc0_dwdata", dwdata, 32'hF00D0000);
      @(posedge clk); #1;
      check("rs_acc1_we", we, 32'h3);
      check("rs_acc1_daddr", daddr, 32'h14);
      check("rs_acc1_dwdata", dwdata, 32'h0000CAFE);
      rst_n = 1'b0;
      #1;
      check("rs_we", we, 32'd0);
      check("rs_valid", resp_valid, 32'd0);
      #2 rst_n = 1'b1;
      check("rs_ready", req_ready, 32'd1);
      run("rs_lw_lo", 1'b0, 3'b010, 32'h10, 32'h0, 2, 1'b0, 32'hF00DBEEF, 1'b0);
      run("rs_lw_hi", 1'b0, 3'b010, 32'h14, 32'h0, 2, 1'b0, 32'h00000012, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
